// File: rtl/seq_multiplier_param_if.sv
// rtl/seq_multiplier_param_if.sv - start/ack control and result bus for the sequential multiplier
interface seq_multiplier_param_if #(
  parameter int WIDTH = 8
);
  logic                   st;
  logic                   signed_mode;
  logic [WIDTH-1:0]       mplier;
  logic [WIDTH-1:0]       mcand;
  logic                   ack;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     result;

  modport master (
    output st, signed_mode, mplier, mcand, ack,
    input  busy, done, result
  );

  modport slave (
    input  st, signed_mode, mplier, mcand, ack,
    output busy, done, result
  );
endinterface

// File: rtl/seq_multiplier_param.sv
// rtl/seq_multiplier_param.sv - parametrised shift-and-add multiplier with sign fix and done/ack handshake
// Signed operands are multiplied as magnitudes; the sign is applied once in a dedicated cycle.
module seq_multiplier_param #(
  parameter int WIDTH     = 8,
  parameter int SIGNED_EN = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  seq_multiplier_param_if.slave mul_if
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  logic                 smode;
  logic [WIDTH-1:0]     mplier_mag;
  logic [WIDTH-1:0]     mcand_mag;
  logic [WIDTH:0]       sum_w;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    result_d   = result_q;
    smode      = mul_if.signed_mode & (SIGNED_EN != 0);
    mplier_mag = (smode && mul_if.mplier[WIDTH-1]) ? -mul_if.mplier : mul_if.mplier;
    mcand_mag  = (smode && mul_if.mcand[WIDTH-1])  ? -mul_if.mcand  : mul_if.mcand;
    // The high half never exceeds WIDTH bits after a shift, so a WIDTH+1 bit sum cannot overflow.
    sum_w      = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});

    unique case (state_q)
      S_IDLE: begin
        if (mul_if.st) begin
          mcand_d = mcand_mag;
          neg_d   = smode & (mul_if.mplier[WIDTH-1] ^ mul_if.mcand[WIDTH-1]);
          acc_d   = {1'b0, {WIDTH{1'b0}}, mplier_mag};
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = {1'b0, sum_w, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_SIGN;
        end
      end
      S_SIGN: begin
        result_d = neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (mul_if.ack) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mul_if.busy   = (state_q == S_CALC) || (state_q == S_SIGN);
  assign mul_if.done   = (state_q == S_DONE);
  assign mul_if.result = result_q;
endmodule

// File: tb/tb_seq_multiplier_param.sv
// tb/tb_seq_multiplier_param.sv - directed and reference-model checks of seq_multiplier_param
module tb_seq_multiplier_param;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  seq_multiplier_param_if #(.WIDTH(8))  b8  ();
  seq_multiplier_param_if #(.WIDTH(8))  b8u ();
  seq_multiplier_param_if #(.WIDTH(16)) b16 ();
  seq_multiplier_param_if #(.WIDTH(3))  b3  ();

  seq_multiplier_param #(.WIDTH(8),  .SIGNED_EN(1)) dut8  (.clk_i(clk), .rst_n_i(rst_n), .mul_if(b8));
  seq_multiplier_param #(.WIDTH(8),  .SIGNED_EN(0)) dut8u (.clk_i(clk), .rst_n_i(rst_n), .mul_if(b8u));
  seq_multiplier_param #(.WIDTH(16), .SIGNED_EN(1)) dut16 (.clk_i(clk), .rst_n_i(rst_n), .mul_if(b16));
  seq_multiplier_param #(.WIDTH(3),  .SIGNED_EN(1)) dut3  (.clk_i(clk), .rst_n_i(rst_n), .mul_if(b3));

  // w: 0 = 8-bit signed-enabled, 1 = 8-bit unsigned-only, 2 = 16-bit, 3 = 3-bit
  task automatic drv(input int w, input logic st, input logic sm, input logic ack,
                     input logic [15:0] a, input logic [15:0] b);
    case (w)
      0: begin b8.st = st;  b8.signed_mode = sm;  b8.ack = ack;  b8.mplier = a[7:0];  b8.mcand = b[7:0];  end
      1: begin b8u.st = st; b8u.signed_mode = sm; b8u.ack = ack; b8u.mplier = a[7:0]; b8u.mcand = b[7:0]; end
      2: begin b16.st = st; b16.signed_mode = sm; b16.ack = ack; b16.mplier = a;      b16.mcand = b;      end
      default: begin b3.st = st; b3.signed_mode = sm; b3.ack = ack; b3.mplier = a[2:0]; b3.mcand = b[2:0]; end
    endcase
  endtask

  function automatic logic [1:0] stat(input int w);
    case (w)
      0: return {b8.busy, b8.done};
      1: return {b8u.busy, b8u.done};
      2: return {b16.busy, b16.done};
      default: return {b3.busy, b3.done};
    endcase
  endfunction

  function automatic logic [31:0] res(input int w);
    case (w)
      0: return {16'h0, b8.result};
      1: return {16'h0, b8u.result};
      2: return b16.result;
      default: return {26'h0, b3.result};
    endcase
  endfunction

  // Starts an operation, then waits (bounded) for Done; lat counts edges after the capture edge.
  task automatic run_op(input int w, input logic sm, input logic [15:0] a, input logic [15:0] b,
                        output logic [31:0] r, output int lat, output int bcnt);
    @(negedge clk);
    drv(w, 1'b1, sm, 1'b0, a, b);
    @(negedge clk);
    drv(w, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    lat = 0;
    bcnt = 0;
    while (!stat(w)[0] && lat < 60) begin
      bcnt += int'(stat(w)[1]);
      @(negedge clk);
      lat++;
    end
    r = res(w);
  endtask

  task automatic ack_op(input int w);
    drv(w, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    @(negedge clk);
    drv(w, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic test_reset;
    for (int w = 0; w < 4; w++) drv(w, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({stat(0), res(0)} !== 34'h0) begin
      failures++;
      $display("FAIL reset_state busy/done=%b result=%h required 00/0000", stat(0), res(0));
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned_max;
    logic [31:0] r;
    int lat, bcnt;
    run_op(0, 1'b0, 16'hFF, 16'hFF, r, lat, bcnt);
    checks++;
    if (r !== 32'hFE01) begin failures++; $display("FAIL umax_result got %h required fe01", r); end
    checks++;
    if (lat !== 9) begin failures++; $display("FAIL umax_latency got %0d required 9", lat); end
    checks++;
    if (bcnt !== 9) begin failures++; $display("FAIL umax_busy_cycles got %0d required 9", bcnt); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (stat(0) !== 2'b01 || res(0) !== 32'hFE01) begin
        failures++;
        $display("FAIL umax_hold cycle %0d busy/done=%b result=%h required 01/fe01", i, stat(0), res(0));
      end
    end
    ack_op(0);
    checks++;
    if (stat(0) !== 2'b00 || res(0) !== 32'hFE01) begin
      failures++;
      $display("FAIL umax_after_ack busy/done=%b result=%h required 00/fe01", stat(0), res(0));
    end
  endtask

  task automatic test_signed;
    logic [15:0] va [4] = '{16'h80, 16'h80, 16'hFD, 16'h00};
    logic [15:0] vb [4] = '{16'h80, 16'h7F, 16'h05, 16'hF9};
    logic [31:0] ve [4] = '{32'h4000, 32'hC080, 32'hFFF1, 32'h0000};
    logic [31:0] r;
    int lat, bcnt;
    for (int i = 0; i < 4; i++) begin
      run_op(0, 1'b1, va[i], vb[i], r, lat, bcnt);
      checks++;
      if (r !== ve[i] || lat !== 9) begin
        failures++;
        $display("FAIL signed_vec %0d result=%h lat=%0d required %h lat=9", i, r, lat, ve[i]);
      end
      ack_op(0);
    end
  endtask

  task automatic test_signed_disabled;
    logic [31:0] r;
    int lat, bcnt;
    run_op(1, 1'b1, 16'hFF, 16'h02, r, lat, bcnt);
    checks++;
    if (r !== 32'h01FE) begin failures++; $display("FAIL signed_disabled got %h required 01fe", r); end
    ack_op(1);
  endtask

  task automatic test_handshake;
    logic [31:0] r;
    int lat, bcnt;
    @(negedge clk);
    drv(0, 1'b1, 1'b0, 1'b0, 16'd6, 16'd7);
    @(negedge clk);
    lat = 0;
    while (!stat(0)[0] && lat < 60) begin
      drv(0, 1'b1, 1'b1, 1'b0, 16'd9 + 16'(lat), 16'd9);
      @(negedge clk);
      lat++;
    end
    checks++;
    if (res(0) !== 32'd42 || lat !== 9) begin
      failures++;
      $display("FAIL st_held result=%h lat=%0d required 002a lat=9", res(0), lat);
    end
    drv(0, 1'b1, 1'b0, 1'b1, 16'd9, 16'd9);
    @(negedge clk);
    checks++;
    if (stat(0) !== 2'b00) begin failures++; $display("FAIL st_ack_together busy/done=%b required 00", stat(0)); end
    drv(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    checks++;
    if (stat(0) !== 2'b00) begin failures++; $display("FAIL no_restart busy/done=%b required 00", stat(0)); end
    run_op(0, 1'b0, 16'd3, 16'd4, r, lat, bcnt);
    checks++;
    if (r !== 32'd12 || lat !== 9) begin
      failures++;
      $display("FAIL back_to_back result=%h lat=%0d required 000c lat=9", r, lat);
    end
    ack_op(0);
  endtask

  task automatic test_reset_midop;
    logic [31:0] r;
    int lat, bcnt;
    @(negedge clk);
    drv(0, 1'b1, 1'b0, 1'b0, 16'd13, 16'd11);
    @(negedge clk);
    drv(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (stat(0) !== 2'b00 || res(0) !== 32'h0) begin
      failures++;
      $display("FAIL midop_reset busy/done=%b result=%h required 00/0000", stat(0), res(0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 1'b0, 16'd13, 16'd11, r, lat, bcnt);
    checks++;
    if (r !== 32'd143 || lat !== 9) begin
      failures++;
      $display("FAIL after_reset result=%h lat=%0d required 008f lat=9", r, lat);
    end
    ack_op(0);
  endtask

  // Reference products come from the simulator's integer multiply on sign- or zero-extended operands.
  task automatic test_width(input int w, input int width, input int n);
    logic [31:0] r, mask, exp;
    logic [15:0] a, b;
    int lat, bcnt, ia, ib;
    mask = (width == 16) ? 32'hFFFF_FFFF : 32'h3F;
    for (int sm = 0; sm < 2; sm++) begin
      for (int i = 0; i < n; i++) begin
        a = 16'($urandom);
        b = 16'($urandom);
        if (i == 0) begin a = 16'h0; end
        if (i == 1) begin a = 16'h1 << (width - 1); b = a; end
        if (width == 3) begin a = {13'h0, a[2:0]}; b = {13'h0, b[2:0]}; end
        if (sm == 1 && width == 16) begin ia = int'($signed(a)); ib = int'($signed(b)); end
        else if (sm == 1) begin ia = int'($signed(a[2:0])); ib = int'($signed(b[2:0])); end
        else begin ia = int'(a); ib = int'(b); end
        exp = 32'(ia * ib) & mask;
        run_op(w, sm[0], a, b, r, lat, bcnt);
        checks++;
        if (r !== exp || lat !== width + 1 || bcnt !== width + 1) begin
          failures++;
          $display("FAIL width%0d mode%0d %h*%h result=%h lat=%0d busy=%0d required %h lat/busy=%0d",
                   width, sm, a, b, r, lat, bcnt, exp, width + 1);
        end
        ack_op(w);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed();
    test_signed_disabled();
    test_handshake();
    test_reset_midop();
    test_width(2, 16, 60);
    test_width(3, 3, 60);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
